// File: rtl/memoria_pkg.sv
// memoria_pkg: shared types and helpers for the memoria_dp memory wrapper.
// Parity support is compiled in by the memoria_dp top when MEMORIA_PARITY_EN is defined.
package memoria_pkg;

   // Clear sequencer states
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Widest data word the parity helper accepts; callers zero-extend into it
   localparam int unsigned PAR_MAX_W = 256;

   // Number of words for a given word-address width
   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

   // Width of the clear-pair counter (DEPTH/2 pairs, at least one bit)
   function automatic int unsigned clr_cnt_w(input int unsigned addr_w);
      return (addr_w > 1) ? addr_w - 1 : 1;
   endfunction

   // Even parity bit: makes the total count of ones in {bit, data} even
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/memoria_dp_array.sv
// memoria_dp_array: behavioural storage with one registered read-first port
// and two independent synchronous write ports. No reset on the array or read register.
module memoria_dp_array
   import memoria_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [WIDTH-1:0]  wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [WIDTH-1:0]  wd1
);

   localparam int unsigned DEPTH = depth_of(ADDR_W);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read samples old contents (read-first); both write ports update the array
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

endmodule

// File: rtl/memoria_dp.sv
// memoria_dp: word-addressed memory with a registered core read port, a debug
// load port (single or pair writes, valid/ready), a hardware clear sequencer and
// a synchronous halt. Define MEMORIA_PARITY_EN to store even parity per word.
module memoria_dp
   import memoria_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              enable_halt,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic              wr_pair,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              clr_start,
   output logic              busy,
   output logic              clr_done,
   output logic              rd_perr
);

   localparam int unsigned DEPTH = depth_of(ADDR_W);
   localparam int unsigned CNT_W = clr_cnt_w(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH / 2 - 1);
`ifdef MEMORIA_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   state_t            state;
   logic [CNT_W-1:0]  clr_cnt;
   logic              has_rd;
   logic [MEM_W-1:0]  arr_rd;
   logic [ADDR_W-1:0] clr_base;
   logic              rd_acc, wr_go, clr_go, clr_last;
   logic              we0, we1;
   logic [ADDR_W-1:0] wa0, wa1;
   logic [MEM_W-1:0]  wd0, wd1;

   // Stored word format: parity bit (if enabled) above the data
   function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef MEMORIA_PARITY_EN
      return {even_parity(PAR_MAX_W'(d)), d};
`else
      return d;
`endif
   endfunction

   assign rd_acc   = rd_en && !enable_halt;
   assign wr_ready = !enable_halt && (state == IDLE);
   assign wr_go    = wr_valid && wr_ready;
   assign clr_go   = !enable_halt && (state == CLEAR);
   assign clr_last = (clr_cnt == CNT_LAST);
   assign clr_base = ADDR_W'({clr_cnt, 1'b0});

   // Write-port steering: clear pairs own both ports while in CLEAR
   always_comb begin
      we0 = 1'b0;
      we1 = 1'b0;
      wa0 = '0;
      wa1 = '0;
      wd0 = '0;
      wd1 = '0;
      if (clr_go) begin
         we0 = 1'b1;
         we1 = 1'b1;
         wa0 = clr_base;
         wa1 = clr_base | ADDR_W'(1);
      end else if (wr_go) begin
         we0 = 1'b1;
         wa0 = wr_addr;
         wd0 = encode(wr_data0);
         we1 = wr_pair;
         wa1 = wr_addr + ADDR_W'(1);  // wraps DEPTH-1 to 0
         wd1 = encode(wr_data1);
      end
   end

   // Clear sequencer FSM with registered busy / clr_done
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state    <= IDLE;
         clr_cnt  <= '0;
         busy     <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         if (!enable_halt) begin
            unique case (state)
               IDLE: begin
                  if (clr_start) begin
                     state   <= CLEAR;
                     busy    <= 1'b1;
                     clr_cnt <= '0;
                  end
               end
               CLEAR: begin
                  if (clr_last) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     clr_done <= 1'b1;
                     clr_cnt  <= '0;
                  end else begin
                     clr_cnt <= clr_cnt + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

   // Read-side status; has_rd masks the unreset array read register until first read
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rd_valid <= 1'b0;
         has_rd   <= 1'b0;
      end else if (!enable_halt) begin
         rd_valid <= rd_en;
         if (rd_en) has_rd <= 1'b1;
      end
   end

   memoria_dp_array #(
      .WIDTH  (MEM_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (Clk),
      .rd_en   (rd_acc),
      .rd_addr (rd_addr),
      .rd_data (arr_rd),
      .we0     (we0),
      .wa0     (wa0),
      .wd0     (wd0),
      .we1     (we1),
      .wa1     (wa1),
      .wd1     (wd1)
   );

   assign rd_data = has_rd ? arr_rd[DATA_W-1:0] : '0;

`ifdef MEMORIA_PARITY_EN
   // Check runs on the registered word, so it holds with rd_data
   assign rd_perr = has_rd && (arr_rd[DATA_W] != even_parity(PAR_MAX_W'(arr_rd[DATA_W-1:0])));
`else
   assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_memoria_dp.sv
// tb_memoria_dp: directed + randomized bench for memoria_dp against a word-array model.
module tb_memoria_dp;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              Clk = 1'b0;
   logic              Rst_n;
   logic              enable_halt;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              wr_valid;
   logic              wr_ready;
   logic              wr_pair;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data0;
   logic [DATA_W-1:0] wr_data1;
   logic              clr_start;
   logic              busy;
   logic              clr_done;
   logic              rd_perr;

   int total = 0;
   int bad   = 0;

   // Reference model: plain word array plus expected read-port state
   logic [DATA_W-1:0] model [DEPTH];
   bit                known [DEPTH];
   logic [DATA_W-1:0] exp_data  = '0;
   bit                exp_known = 1'b1;
   logic              exp_valid = 1'b0;

   memoria_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .enable_halt (enable_halt),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_pair     (wr_pair),
      .wr_addr     (wr_addr),
      .wr_data0    (wr_data0),
      .wr_data1    (wr_data1),
      .clr_start   (clr_start),
      .busy        (busy),
      .clr_done    (clr_done),
      .rd_perr     (rd_perr)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      enable_halt = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = '0;
      wr_valid    = 1'b0;
      wr_pair     = 1'b0;
      wr_addr     = '0;
      wr_data0    = '0;
      wr_data1    = '0;
      clr_start   = 1'b0;
   endtask

   // One clock with the current inputs, outside any clear; model then compare
   task automatic cycle();
      int a1;
      if (!enable_halt) begin
         if (rd_en) begin
            exp_valid = 1'b1;
            exp_data  = model[rd_addr];
            exp_known = known[rd_addr];
         end else begin
            exp_valid = 1'b0;
         end
         if (wr_valid) begin
            model[wr_addr] = wr_data0;
            known[wr_addr] = 1'b1;
            if (wr_pair) begin
               a1 = (int'(wr_addr) + 1) % DEPTH;
               model[a1] = wr_data1;
               known[a1] = 1'b1;
            end
         end
      end
      @(posedge Clk);
      #1;
      chk("rd_valid", rd_valid, exp_valid);
      if (exp_known) chk("rd_data", rd_data, exp_data);
      chk("rd_perr", rd_perr, 1'b0);
   endtask

   task automatic write(input int addr, input logic [DATA_W-1:0] d0, input bit pair,
                        input logic [DATA_W-1:0] d1);
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(addr);
      wr_data0 = d0;
      wr_data1 = d1;
      wr_pair  = pair;
      cycle();
      wr_valid = 1'b0;
      wr_pair  = 1'b0;
   endtask

   task automatic read(input int addr);
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(addr);
      cycle();
      rd_en = 1'b0;
   endtask

   initial begin
      int n, busy_cycles, done_cnt, rdy_bad;
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      idle_inputs();
      Rst_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_rd_data", rd_data, 32'h0);
      chk("reset_rd_valid", rd_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_clr_done", clr_done, 1'b0);
      chk("reset_rd_perr", rd_perr, 1'b0);
      Rst_n = 1'b1;
      #1;
      chk("wr_ready_after_reset", wr_ready, 1'b1);

      // Single write then read
      write(5, 32'h1111_1111, 1'b0, 32'h0);
      read(5);
      chk("read5_data", rd_data, 32'h1111_1111);
      chk("read5_valid", rd_valid, 1'b1);
      cycle();
      chk("no_read_valid_low", rd_valid, 1'b0);
      chk("no_read_data_hold", rd_data, 32'h1111_1111);

      // Pair write wrapping past the last word
      write(DEPTH - 1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002);
      read(DEPTH - 1);
      chk("pair_last", rd_data, 32'hAAAA_0001);
      read(0);
      chk("pair_wrap0", rd_data, 32'hBBBB_0002);

      // Read-first collision
      write(7, 32'h0, 1'b0, 32'h0);
      rd_en = 1'b1;
      rd_addr = 7;
      write(7, 32'hDEAD_BEEF, 1'b0, 32'h0);
      rd_en = 1'b0;
      chk("read_first_old", rd_data, 32'h0);
      read(7);
      chk("read_after_write", rd_data, 32'hDEAD_BEEF);

      // Fill the whole array with pair writes
      for (int a = 0; a < DEPTH; a += 2) write(a, $urandom, 1'b1, $urandom);

      // Clear with a 3-cycle halt in the middle; a write is offered throughout
      clr_start = 1'b1;
      @(posedge Clk);
      #1;
      clr_start   = 1'b0;
      wr_valid    = 1'b1;
      wr_addr     = 9;
      wr_data0    = 32'hCAFE_F00D;
      busy_cycles = 0;
      done_cnt    = 0;
      rdy_bad     = 0;
      n           = 0;
      while (n < 5000 && done_cnt == 0) begin
         if (busy) busy_cycles++;
         if (wr_ready) rdy_bad++;
         enable_halt = (n >= 100 && n < 103);
         @(posedge Clk);
         #1;
         n++;
         if (clr_done) done_cnt++;
      end
      wr_valid    = 1'b0;
      enable_halt = 1'b0;
      chk("clr_done_seen", done_cnt, 1);
      chk("busy_low_at_done", busy, 1'b0);
      chk("busy_length", busy_cycles, DEPTH / 2 + 3);
      chk("wr_ready_low_in_clear", rdy_bad, 0);
      repeat (5) begin
         @(posedge Clk);
         #1;
         if (clr_done) done_cnt++;
      end
      chk("clr_done_once", done_cnt, 1);
      for (int a = 0; a < DEPTH; a++) begin
         model[a] = '0;
         known[a] = 1'b1;
      end
      for (int a = 0; a < DEPTH; a++) read(a);

      // Halt holds outputs and blocks the write
      write(20, 32'h1234_5678, 1'b0, 32'h0);
      read(20);
      chk("pre_halt_data", rd_data, 32'h1234_5678);
      enable_halt = 1'b1;
      rd_en       = 1'b1;
      rd_addr     = 21;
      wr_valid    = 1'b1;
      wr_pair     = 1'b1;
      wr_addr     = 20;
      wr_data0    = 32'hFFFF_0000;
      wr_data1    = 32'hFFFF_1111;
      #1;
      chk("halt_wr_ready", wr_ready, 1'b0);
      repeat (3) cycle();
      chk("halt_hold_data", rd_data, 32'h1234_5678);
      chk("halt_hold_valid", rd_valid, 1'b1);
      idle_inputs();
      read(20);
      chk("halt_no_write20", rd_data, 32'h1234_5678);
      read(21);
      chk("halt_no_write21", rd_data, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         enable_halt = ($urandom_range(0, 4) == 0);
         rd_en       = $urandom_range(0, 1);
         rd_addr     = ADDR_W'($urandom);
         wr_valid    = $urandom_range(0, 1);
         wr_pair     = $urandom_range(0, 1);
         wr_addr     = ADDR_W'($urandom);
         wr_data0    = $urandom;
         wr_data1    = $urandom;
         #1;
         chk("rand_wr_ready", wr_ready, !enable_halt);
         cycle();
      end
      idle_inputs();

      // Reset mid-clear aborts without clr_done
      clr_start = 1'b1;
      @(posedge Clk);
      #1;
      clr_start = 1'b0;
      repeat (10) @(posedge Clk);
      #3;
      Rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_rd_data", rd_data, 32'h0);
      chk("abort_rd_valid", rd_valid, 1'b0);
      #2;
      Rst_n = 1'b1;
      done_cnt = 0;
      repeat (DEPTH) begin
         @(posedge Clk);
         #1;
         if (clr_done || busy) done_cnt++;
      end
      chk("abort_no_done", done_cnt, 0);

`ifdef MEMORIA_PARITY_EN
      // Parity: clean read then a flipped stored bit
      for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
      exp_known = 1'b0;
      write(3, 32'h0F0F_0F0F, 1'b0, 32'h0);
      read(3);
      chk("parity_clean", rd_perr, 1'b0);
      dut.u_array.mem[3] = dut.u_array.mem[3] ^ 33'h1;
      rd_en   = 1'b1;
      rd_addr = 3;
      @(posedge Clk);
      #1;
      rd_en = 1'b0;
      chk("parity_flip", rd_perr, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
